// File: rtl/conductance_leak_engine.sv
// Multi-channel exponential conductance decay: g <- g - g*k[ch], with k = dT/tau
// computed per channel by a bit-serial reciprocal divider on each tau load.
module conductance_leak_engine #(
    parameter int INTEGER_WIDTH   = 32,
    parameter int DATA_WIDTH_FRAC = 32,
    parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
    parameter int DELTAT_WIDTH    = 4,
    parameter int CHANNELS        = 2,
    parameter int CH_WIDTH        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                            Clock,
    input  logic                            Reset,
    input  logic [DELTAT_WIDTH-1:0]         DeltaT,
    input  logic                            TauLoad,
    input  logic [CH_WIDTH-1:0]             TauChannel,
    input  logic signed [INTEGER_WIDTH-1:0] Tau,
    output logic                            TauReady,
    output logic                            TauError,
    input  logic                            InValid,
    output logic                            InReady,
    input  logic [CH_WIDTH-1:0]             InChannel,
    input  logic signed [DATA_WIDTH-1:0]    InG,
    output logic                            OutValid,
    input  logic                            OutReady,
    output logic [CH_WIDTH-1:0]             OutChannel,
    output logic signed [DATA_WIDTH-1:0]    OutG
);
    localparam int F  = DATA_WIDTH_FRAC;
    localparam int PW = DATA_WIDTH + F + 1;
    localparam int CW = $clog2(F + 1);
    localparam logic [F:0] ONE = {1'b1, {F{1'b0}}};

    typedef enum logic [1:0] {IDLE, DIVIDE, SCALE} state_t;

    state_t                     state;
    logic                       tau_ready, tau_error;
    logic [CW-1:0]              cnt;
    logic [F:0]                 k [CHANNELS];
    logic [INTEGER_WIDTH-1:0]   tau_q, rem;
    logic [DELTAT_WIDTH-1:0]    dt_q;
    logic [CH_WIDTH-1:0]        ch_q;
    logic [F:0]                 quo;
    logic [INTEGER_WIDTH:0]     rem_sh, rem_diff;
    logic                       rem_ge;

    logic                       vld_p1, vld_p2;
    logic [CH_WIDTH-1:0]        ch_p1;
    logic signed [DATA_WIDTH-1:0] g_p1;
    logic signed [PW-1:0]       prod_p1;
    logic [F:0]                 k_in;
    logic                       s1_load, s2_load, in_ready, in_accept, tau_accept;
    logic                       tau_bad, in_bad;

    function automatic logic ch_ok(input logic [CH_WIDTH-1:0] ch);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < CHANNELS; c++)
            if (ch == CH_WIDTH'(c)) hit = 1'b1;
        return hit;
    endfunction

    function automatic logic [F:0] scale_coef(input logic [F:0] r, input logic [DELTAT_WIDTH-1:0] dt);
        logic [F+DELTAT_WIDTH:0] p, s;
        p = {{DELTAT_WIDTH{1'b0}}, r} * {{(F+1){1'b0}}, dt};
        s = p >> DELTAT_WIDTH;
        if (s > {{DELTAT_WIDTH{1'b0}}, ONE}) return ONE;
        return s[F:0];
    endfunction

    function automatic logic signed [PW-1:0] mul_coef(input logic signed [DATA_WIDTH-1:0] g,
                                                      input logic [F:0] kc);
        logic signed [PW-1:0] gx, kx;
        gx = {{(F+1){g[DATA_WIDTH-1]}}, g};
        kx = {{DATA_WIDTH{1'b0}}, kc};
        return gx * kx;
    endfunction

    // Truncating (floor) decay; 0 <= k <= 1 keeps the result between 0 and g.
    function automatic logic signed [DATA_WIDTH-1:0] apply_decay(input logic signed [DATA_WIDTH-1:0] g,
                                                                 input logic signed [PW-1:0] p);
        logic signed [PW-1:0] gx, d, r;
        gx = {{(F+1){g[DATA_WIDTH-1]}}, g};
        d  = p >>> F;
        r  = gx - d;
        return r[DATA_WIDTH-1:0];
    endfunction

    always_comb begin
        k_in = '0;
        for (int c = 0; c < CHANNELS; c++)
            if (InChannel == CH_WIDTH'(c)) k_in = k[c];
        rem_sh   = {rem, cnt == CW'(F)};
        rem_diff = rem_sh - {1'b0, tau_q};
        rem_ge   = ~rem_diff[INTEGER_WIDTH];
    end

    assign s2_load    = ~vld_p2 | OutReady;
    assign s1_load    = ~vld_p1 | s2_load;
    assign in_ready   = (state == IDLE) & s1_load;
    assign in_accept  = InValid & in_ready;
    assign tau_accept = TauLoad & tau_ready;
    assign tau_bad    = tau_accept & ((Tau <= 0) | ~ch_ok(TauChannel));
    assign in_bad     = in_accept & ~ch_ok(InChannel);

    assign InReady  = in_ready;
    assign OutValid = vld_p2;
    assign TauReady = tau_ready;
    assign TauError = tau_error;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            tau_ready <= 1'b1;
            tau_error <= 1'b0;
            cnt       <= '0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            OutG      <= '0;
            OutChannel <= '0;
            for (int c = 0; c < CHANNELS; c++) k[c] <= '0;
        end else begin
            tau_error <= tau_error | tau_bad | in_bad;
            case (state)
                IDLE: begin
                    if (tau_accept) begin
                        if (tau_bad) begin
                            for (int c = 0; c < CHANNELS; c++)
                                if (TauChannel == CH_WIDTH'(c)) k[c] <= '0;
                        end else begin
                            state     <= DIVIDE;
                            tau_ready <= 1'b0;
                            cnt       <= CW'(F);
                        end
                    end
                end
                DIVIDE: begin
                    if (cnt == '0) state <= SCALE;
                    else           cnt   <= cnt - CW'(1);
                end
                SCALE: begin
                    for (int c = 0; c < CHANNELS; c++)
                        if (ch_q == CH_WIDTH'(c)) k[c] <= scale_coef(quo, dt_q);
                    state     <= IDLE;
                    tau_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    tau_ready <= 1'b1;
                end
            endcase
            if (s1_load) vld_p1 <= in_accept;
            if (s2_load) vld_p2 <= vld_p1;
            // S1 -> S2: subtract the shifted product
            if (s2_load && vld_p1) begin
                OutG       <= apply_decay(g_p1, prod_p1);
                OutChannel <= ch_p1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (tau_accept) begin
            tau_q <= Tau;
            dt_q  <= DeltaT;
            ch_q  <= TauChannel;
            rem   <= '0;
            quo   <= '0;
        end else if (state == DIVIDE) begin
            rem <= rem_ge ? rem_diff[INTEGER_WIDTH-1:0] : rem_sh[INTEGER_WIDTH-1:0];
            quo <= {quo[F-1:0], rem_ge};
        end
        // Input -> S1: capture sample and its product with the current k
        if (in_accept) begin
            g_p1    <= InG;
            ch_p1   <= InChannel;
            prod_p1 <= mul_coef(InG, k_in);
        end
    end
endmodule

// File: tb/tb_conductance_leak_engine.sv
// Self-checking bench for conductance_leak_engine: directed scenarios plus a
// randomized run against an arithmetic reference model and scoreboard.
module tb_conductance_leak_engine;
    localparam int CH  = 2;
    localparam int CHW = 1;

    logic               Clock = 1'b0;
    logic               Reset;
    logic [3:0]         DeltaT;
    logic               TauLoad;
    logic [CHW-1:0]     TauChannel;
    logic signed [31:0] Tau;
    logic               TauReady, TauError;
    logic               InValid, InReady;
    logic [CHW-1:0]     InChannel;
    logic signed [63:0] InG;
    logic               OutValid, OutReady;
    logic [CHW-1:0]     OutChannel;
    logic signed [63:0] OutG;

    conductance_leak_engine dut (
        .Clock(Clock), .Reset(Reset), .DeltaT(DeltaT), .TauLoad(TauLoad),
        .TauChannel(TauChannel), .Tau(Tau), .TauReady(TauReady), .TauError(TauError),
        .InValid(InValid), .InReady(InReady), .InChannel(InChannel), .InG(InG),
        .OutValid(OutValid), .OutReady(OutReady), .OutChannel(OutChannel), .OutG(OutG)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int failures = 0;

    typedef struct {logic [CHW-1:0] ch; logic [63:0] g;} item_t;
    item_t exp_q[$];
    item_t got_q[$];
    logic [32:0] mk [CH];
    logic merr;

    function automatic logic [32:0] model_k(input int tau, input int dt);
        longint unsigned recip, v;
        if (tau <= 0) return 33'd0;
        recip = 64'h1_0000_0000 / longint'(tau);
        v = (recip * longint'(dt)) >> 4;
        if (v > 64'h1_0000_0000) v = 64'h1_0000_0000;
        return v[32:0];
    endfunction

    function automatic logic [63:0] model_out(input logic [63:0] g, input logic [32:0] k);
        logic signed [127:0] gw, kw, p, d, r;
        gw = {{64{g[63]}}, g};
        kw = {95'd0, k};
        p = gw * kw;
        d = p >>> 32;
        r = gw - d;
        return r[63:0];
    endfunction

    // Scoreboard: records accepted samples (with model result) and emitted results.
    always @(negedge Clock) begin
        if (Reset) begin
            exp_q.delete(); got_q.delete();
            for (int c = 0; c < CH; c++) mk[c] = '0;
            merr = 1'b0;
        end else begin
            if (InValid && InReady) exp_q.push_back('{InChannel, model_out(InG, mk[InChannel])});
            if (OutValid && OutReady) got_q.push_back('{OutChannel, OutG});
            if (TauLoad && TauReady) begin
                if (Tau <= 0) merr = 1'b1;
                mk[TauChannel] = model_k(Tau, int'(DeltaT));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge Clock); #1; end
    endtask

    task automatic send(input logic [CHW-1:0] ch, input logic [63:0] g);
        logic acc;
        acc = 1'b0;
        InValid = 1'b1; InChannel = ch; InG = g;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge Clock); acc = InReady;
            @(posedge Clock); #1;
        end
        InValid = 1'b0;
        if (!acc) begin
            checks++; failures++;
            $display("FAIL send_timeout: InReady stayed 0, required 1");
        end
    endtask

    task automatic load(input logic [CHW-1:0] ch, input int tau, input int dt, output int cyc);
        logic acc;
        TauLoad = 1'b1; TauChannel = ch; Tau = tau; DeltaT = 4'(dt);
        @(negedge Clock); acc = TauReady;
        @(posedge Clock); #1;
        TauLoad = 1'b0;
        cyc = 1;
        while (!TauReady && cyc < 100) begin step(1); cyc++; end
        if (!acc) begin
            checks++; failures++;
            $display("FAIL load_accept: TauReady=0 at load, required 1");
        end
    endtask

    task automatic wait_drain();
        int i;
        i = 0;
        while ((got_q.size() < exp_q.size() || OutValid) && i < 500) begin step(1); i++; end
        if (i >= 500) begin
            checks++; failures++;
            $display("FAIL drain_timeout: got %0d results, required %0d", got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; InValid = 1'b0; TauLoad = 1'b0; OutReady = 1'b1;
        InChannel = '0; InG = '0; TauChannel = '0; Tau = '0; DeltaT = '0;
        step(2);
        Reset = 1'b0;
        checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL reset_outvalid: got %b required 0", OutValid); end
        checks++; if (OutG !== 64'd0) begin failures++; $display("FAIL reset_outg: got %h required 0", OutG); end
        checks++; if (OutChannel !== '0) begin failures++; $display("FAIL reset_outch: got %0d required 0", OutChannel); end
        checks++; if (TauReady !== 1'b1) begin failures++; $display("FAIL reset_tauready: got %b required 1", TauReady); end
        checks++; if (TauError !== 1'b0) begin failures++; $display("FAIL reset_tauerror: got %b required 0", TauError); end
        checks++; if (InReady !== 1'b1) begin failures++; $display("FAIL reset_inready: got %b required 1", InReady); end
    endtask

    task automatic test_load_latency();
        int cyc;
        load(0, 4, 4, cyc);
        checks++; if (cyc != 35) begin failures++; $display("FAIL load_cycles: got %0d required 35", cyc); end
        exp_q.delete(); got_q.delete();
        send(0, 64'h1_0000_0000);
        checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL latency_early: OutValid %b required 0", OutValid); end
        step(1);
        checks++; if (OutValid !== 1'b1) begin failures++; $display("FAIL latency_n2: OutValid %b required 1", OutValid); end
        checks++; if (OutG !== 64'h0_F000_0000) begin failures++; $display("FAIL decay_pos: got %h required 00000000f0000000", OutG); end
        wait_drain();
    endtask

    task automatic test_negative();
        exp_q.delete(); got_q.delete();
        send(0, 64'hFFFF_FFFF_0000_0000);
        send(0, 64'h0);
        wait_drain();
        checks++;
        if (got_q.size() != 2) begin failures++; $display("FAIL neg_count: got %0d required 2", got_q.size()); end
        else begin
            checks++; if (got_q[0].g !== 64'hFFFF_FFFF_1000_0000) begin failures++; $display("FAIL decay_neg: got %h required ffffffff10000000", got_q[0].g); end
            checks++; if (got_q[1].g !== 64'h0) begin failures++; $display("FAIL decay_zero: got %h required 0", got_q[1].g); end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] gs [3];
        logic [CHW-1:0] chs [3];
        logic [63:0] held;
        int acc, idx;
        logic a;
        gs = '{64'h2_0000_0000, 64'h3_0000_0000, 64'h4_0000_0000};
        chs = '{1'b0, 1'b1, 1'b0};
        exp_q.delete(); got_q.delete();
        OutReady = 1'b0; acc = 0; idx = 0;
        for (int c = 0; c < 4; c++) begin
            InValid = 1'b1; InChannel = chs[idx]; InG = gs[idx];
            @(negedge Clock); a = InReady;
            @(posedge Clock); #1;
            if (a && idx < 2) idx++;
            if (a) acc++;
        end
        InValid = 1'b0;
        checks++; if (acc != 2) begin failures++; $display("FAIL bp_accepted: got %0d required 2", acc); end
        checks++; if (InReady !== 1'b0) begin failures++; $display("FAIL bp_inready: got %b required 0", InReady); end
        checks++; if (OutG !== 64'h1_E000_0000 || OutValid !== 1'b1) begin failures++; $display("FAIL bp_head: got %h/%b required 00000001e0000000/1", OutG, OutValid); end
        held = OutG;
        step(3);
        checks++; if (OutG !== held || OutChannel !== 1'b0 || OutValid !== 1'b1) begin failures++; $display("FAIL bp_hold: got %h ch %0d required %h ch 0", OutG, OutChannel, held); end
        OutReady = 1'b1;
        wait_drain();
        checks++;
        if (got_q.size() != 2) begin failures++; $display("FAIL bp_count: got %0d required 2", got_q.size()); end
        else begin
            checks++; if (got_q[0].ch !== 1'b0 || got_q[0].g !== 64'h1_E000_0000) begin failures++; $display("FAIL bp_first: got ch%0d %h required ch0 00000001e0000000", got_q[0].ch, got_q[0].g); end
            checks++; if (got_q[1].ch !== 1'b1 || got_q[1].g !== 64'h3_0000_0000) begin failures++; $display("FAIL bp_second: got ch%0d %h required ch1 0000000300000000", got_q[1].ch, got_q[1].g); end
        end
    endtask

    task automatic test_load_inflight();
        logic a_in, a_tau, low_ok;
        int cyc;
        exp_q.delete(); got_q.delete();
        InValid = 1'b1; InChannel = 0; InG = 64'h1_0000_0000;
        step(1);
        InG = 64'h2_0000_0000;
        TauLoad = 1'b1; TauChannel = 1; Tau = 2; DeltaT = 4'd8;
        @(negedge Clock); a_in = InReady; a_tau = TauReady;
        @(posedge Clock); #1;
        InValid = 1'b0; TauLoad = 1'b0;
        checks++; if (!(a_in && a_tau)) begin failures++; $display("FAIL same_cycle_accept: in %b tau %b required 1 1", a_in, a_tau); end
        checks++; if (InReady !== 1'b0) begin failures++; $display("FAIL inready_drop: got %b required 0", InReady); end
        cyc = 1; low_ok = 1'b1;
        while (!TauReady && cyc < 100) begin
            if (InReady !== 1'b0) low_ok = 1'b0;
            if (cyc == 3) begin TauLoad = 1'b1; TauChannel = 0; Tau = 1; DeltaT = 4'd15; end
            else TauLoad = 1'b0;
            step(1); cyc++;
        end
        TauLoad = 1'b0;
        checks++; if (cyc != 35) begin failures++; $display("FAIL inflight_cycles: got %0d required 35", cyc); end
        checks++; if (!low_ok) begin failures++; $display("FAIL busy_inready: InReady rose during update, required 0"); end
        wait_drain();
        checks++;
        if (got_q.size() != 2) begin failures++; $display("FAIL inflight_count: got %0d required 2", got_q.size()); end
        else begin
            checks++; if (got_q[0].g !== 64'h0_F000_0000) begin failures++; $display("FAIL inflight_old0: got %h required 00000000f0000000", got_q[0].g); end
            checks++; if (got_q[1].g !== 64'h1_E000_0000) begin failures++; $display("FAIL inflight_old1: got %h required 00000001e0000000", got_q[1].g); end
        end
        exp_q.delete(); got_q.delete();
        send(1, 64'h1_0000_0000);
        send(0, 64'h1_0000_0000);
        wait_drain();
        checks++;
        if (got_q.size() != 2) begin failures++; $display("FAIL newk_count: got %0d required 2", got_q.size()); end
        else begin
            checks++; if (got_q[0].ch !== 1'b1 || got_q[0].g !== 64'h0_C000_0000) begin failures++; $display("FAIL newk_ch1: got ch%0d %h required ch1 00000000c0000000", got_q[0].ch, got_q[0].g); end
            checks++; if (got_q[1].g !== 64'h0_F000_0000) begin failures++; $display("FAIL busy_load_ignored: got %h required 00000000f0000000", got_q[1].g); end
        end
    endtask

    task automatic test_tau_error();
        int cyc;
        load(0, 0, 4, cyc);
        checks++; if (cyc != 1) begin failures++; $display("FAIL err_ready: TauReady back after %0d cycles, required 1", cyc); end
        checks++; if (TauError !== 1'b1) begin failures++; $display("FAIL err_flag: got %b required 1", TauError); end
        exp_q.delete(); got_q.delete();
        send(0, 64'h5_0000_0000);
        send(1, 64'h1_0000_0000);
        wait_drain();
        checks++;
        if (got_q.size() != 2) begin failures++; $display("FAIL err_count: got %0d required 2", got_q.size()); end
        else begin
            checks++; if (got_q[0].g !== 64'h5_0000_0000) begin failures++; $display("FAIL err_passthru: got %h required 0000000500000000", got_q[0].g); end
            checks++; if (got_q[1].g !== 64'h0_C000_0000) begin failures++; $display("FAIL err_other_ch: got %h required 00000000c0000000", got_q[1].g); end
        end
        step(3);
        checks++; if (TauError !== 1'b1) begin failures++; $display("FAIL err_sticky: got %b required 1", TauError); end
    endtask

    task automatic test_reset_mid_divide();
        OutReady = 1'b0;
        send(1, 64'h1_0000_0000);
        TauLoad = 1'b1; TauChannel = 0; Tau = 3; DeltaT = 4'd5;
        step(1);
        TauLoad = 1'b0;
        step(9);
        checks++; if (TauReady !== 1'b0 || OutValid !== 1'b1) begin failures++; $display("FAIL pre_reset: TauReady %b OutValid %b required 0 1", TauReady, OutValid); end
        Reset = 1'b1;
        step(1);
        Reset = 1'b0;
        checks++; if (TauReady !== 1'b1 || OutValid !== 1'b0 || InReady !== 1'b1) begin failures++; $display("FAIL mid_reset: TauReady %b OutValid %b InReady %b required 1 0 1", TauReady, OutValid, InReady); end
        checks++; if (TauError !== 1'b0) begin failures++; $display("FAIL mid_reset_err: got %b required 0", TauError); end
        OutReady = 1'b1;
        exp_q.delete(); got_q.delete();
        send(0, 64'h5_0000_0000);
        send(1, 64'hFFFF_FFFD_0000_0000);
        wait_drain();
        checks++;
        if (got_q.size() != 2) begin failures++; $display("FAIL post_reset_count: got %0d required 2", got_q.size()); end
        else begin
            checks++; if (got_q[0].g !== 64'h5_0000_0000) begin failures++; $display("FAIL post_reset_k0: got %h required 0000000500000000", got_q[0].g); end
            checks++; if (got_q[1].g !== 64'hFFFF_FFFD_0000_0000) begin failures++; $display("FAIL post_reset_k1: got %h required fffffffd00000000", got_q[1].g); end
        end
    endtask

    task automatic test_random();
        exp_q.delete(); got_q.delete();
        for (int c = 0; c < 3000; c++) begin
            OutReady  = ($urandom_range(0, 3) != 0);
            InValid   = ($urandom_range(0, 2) != 0);
            InChannel = CHW'($urandom_range(0, CH - 1));
            InG       = {$urandom, $urandom};
            TauLoad   = ($urandom_range(0, 99) == 0);
            TauChannel = CHW'($urandom_range(0, CH - 1));
            Tau       = ($urandom_range(0, 7) == 0) ? -int'($urandom_range(0, 20)) : int'($urandom_range(1, 5000));
            DeltaT    = 4'($urandom_range(0, 15));
            step(1);
        end
        InValid = 1'b0; TauLoad = 1'b0; OutReady = 1'b1;
        while (!TauReady) step(1);
        wait_drain();
        checks++;
        if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rnd_count: got %0d required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i].ch !== exp_q[i].ch || got_q[i].g !== exp_q[i].g) begin
                failures++;
                $display("FAIL rnd_item %0d: got ch%0d %h required ch%0d %h", i, got_q[i].ch, got_q[i].g, exp_q[i].ch, exp_q[i].g);
            end
        end
        checks++; if (TauError !== merr) begin failures++; $display("FAIL rnd_error: got %b required %b", TauError, merr); end
    endtask

    initial begin
        test_reset();
        test_load_latency();
        test_negative();
        test_backpressure();
        test_load_inflight();
        test_tau_error();
        test_reset_mid_divide();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/conductance_leak_engine.md
# conductance_leak_engine

Sequential, multi-channel successor to the combinational conductance leak unit. It applies the exponential-decay update g ← g − g·ΔT/τ to a stream of synaptic conductances. Each channel (excitatory, inhibitory, …) keeps its own precomputed decay coefficient. Coefficients are derived once per τ load by an iterative reciprocal divider, so the per-sample path needs one multiply and no divider. It sits between the neuron-state memory read port and the write-back path in the neuron update pipeline.

## Interface
- INTEGER_WIDTH, 32, integer bits of conductance and τ
- DATA_WIDTH_FRAC, 32, fractional bits (F)
- DATA_WIDTH, INTEGER_WIDTH+DATA_WIDTH_FRAC, conductance word width
- DELTAT_WIDTH, 4, ΔT width; ΔT is an unsigned fraction, ΔT/2^DELTAT_WIDTH
- CHANNELS, 2, number of conductance channels with independent τ
- CH_WIDTH, $clog2(CHANNELS) (min 1), channel index width

- Clock  in  1  single clock, all state on rising edge
- Reset  in  1  synchronous, active-high
- DeltaT  in  DELTAT_WIDTH  time step; sampled only on an accepted TauLoad
- TauLoad  in  1  request a coefficient update
- TauChannel  in  CH_WIDTH  channel being updated
- Tau  in  INTEGER_WIDTH  signed time constant, integer ms
- TauReady  out  1  high when idle; TauLoad is accepted only when TauReady=1
- TauError  out  1  sticky; set when a loaded Tau ≤ 0 or TauChannel ≥ CHANNELS; cleared only by Reset
- InValid  in  1  sample valid
- InReady  out  1  sample accepted when InValid & InReady
- InChannel  in  CH_WIDTH  channel of sample
- InG  in  DATA_WIDTH  signed Q(I.F) conductance
- OutValid  out  1  result valid
- OutReady  in  1  downstream accept
- OutChannel  out  CH_WIDTH  channel, passed through
- OutG  out  DATA_WIDTH  signed Q(I.F) decayed conductance

## Operation
- Coefficient register per channel: k[c], unsigned, F+1 bits, range 0 to 1.0 (1.0 = 2^F). Reset value is 0, so samples pass through unchanged.
- Coefficient FSM states: IDLE, DIVIDE, SCALE.
  - IDLE: TauReady=1. On an accepted TauLoad, latch Tau, DeltaT and TauChannel.
    - If Tau ≤ 0 or TauChannel is out of range: set TauError and stay in IDLE. Leave k unchanged if the channel is out of range; otherwise write k[c]=0.
    - Otherwise go to DIVIDE.
  - DIVIDE: restoring divider, one quotient bit per cycle, F+1 cycles. It computes recip = floor(2^F / Tau), which needs F+1 bits (Tau=1 gives 2^F). Then go to SCALE.
  - SCALE: one cycle. k[c] = min(2^F, (recip·DeltaT) >> DELTAT_WIDTH), truncating. Write k[c], then return to IDLE.
- TauLoad while TauReady=0 is ignored and has no side effects.
- InReady is 0 for the whole of DIVIDE and SCALE. This prevents samples from being processed against a half-updated coefficient.
- Sample path, two stages with valid/ready backpressure:
  - S1 (on accept): p = InG · k[InChannel], signed×unsigned product, DATA_WIDTH+F+1 bits, registered with the channel and InG.
  - S2: d = p >>> F (arithmetic shift, truncation toward −∞). OutG = g − d, held in the output register.
  - Because 0 ≤ k ≤ 1, the result lies between 0 and g inclusive, so no overflow is possible.
- A sample with InChannel ≥ CHANNELS uses k=0 (pass-through) and sets TauError.
- Pipeline advance rules:
  - S2 loads when it is empty or OutReady=1.
  - S1 loads when it is empty or S2 loads.
  - InReady = (FSM in IDLE) & (S1 empty or S1 advancing).
- Samples already in S1/S2 when a TauLoad is accepted complete with the old k. Their product is already registered.
- Ordering is strictly FIFO. There is no drop or duplication under any OutReady pattern.

## Timing
- Reset values: OutValid=0, OutG=0, OutChannel=0, TauReady=1, TauError=0, InReady=1, all k=0, FSM=IDLE, both stages empty.
- Reset asserted mid-DIVIDE aborts the update. The target k stays at its pre-load value (only SCALE writes k), but Reset also zeroes all k.
- Sample latency: accept in cycle n gives OutValid in cycle n+2 when OutReady stays high. Throughput is 1 sample per cycle.
- Coefficient load: accept in cycle n, DIVIDE for cycles n+1 to n+F+1, SCALE in cycle n+F+2, TauReady=1 again in cycle n+F+3. That is 35 cycles at F=32.
- OutValid, once high, holds and OutG/OutChannel stay stable until OutReady=1.
- TauLoad and InValid in the same IDLE cycle: both are accepted. The sample uses the old k, and InReady drops the next cycle.

## Test plan
- Tau=4, DeltaT=4 on channel 0: k[0]=0x1000_0000 (0.0625) after 35 cycles. Then InG=0x1_0000_0000 (1.0) gives OutG=0x0_F000_0000 two cycles later.
- InG=−1.0 (0xFFFF_FFFF_0000_0000) on the same channel gives OutG=0xFFFF_FFFF_1000_0000 (−0.9375). InG=0 gives 0.
- Tau=0 load gives TauError=1, TauReady back to 1 the next cycle, and k=0. Then InG=0x5_0000_0000 gives OutG unchanged.
- Hold OutReady=0 and send 3 back-to-back samples: only 2 are accepted, and InReady goes low. Release OutReady: all outputs arrive in order with correct channel tags.
- Load channel 1 (Tau=2, DeltaT=8) while channel-0 samples are in flight. In-flight results use the old k, InReady=0 for 35 cycles, and the next channel-1 sample with g=1.0 gives 0x0_C000_0000.
- Assert Reset at cycle 10 of DIVIDE: TauReady=1, all k=0, and no output is emitted the following cycle. A subsequent sample passes through unchanged.
